// File: rtl/pm_phase_pkg.sv
// Shared types and helpers for the PLL phase-step responder.
//   state_e    : handshake FSM states
//   phase_step : one-unit phase move, modulo or saturating at the period bounds
package pm_phase_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        BUSY    = 3'd2,
        APPLY   = 3'd3,
        RELEASE = 3'd4
    } state_e;

    // Step cur by +/-1 within 0..period-1; wrap selects modulo vs saturate at the ends.
    function automatic int unsigned phase_step(input int unsigned cur,
                                               input logic        up,
                                               input int unsigned period,
                                               input logic        wrap);
        if (up) begin
            if (cur >= period - 1) return wrap ? 0 : period - 1;
            return cur + 1;
        end
        if (cur == 0) return wrap ? period - 1 : 0;
        return cur - 1;
    endfunction

endpackage

// File: rtl/pm_phase_nco.sv
// Period counter and phase-offset comparator producing the shifted square wave.
//   clk100  : system clock
//   reset   : asynchronous, active-high
//   phase   : offset in clk100 cycles, 0..PERIOD-1
//   clk_out : registered square wave, PERIOD cycles, high for the first half
module pm_phase_nco
    import pm_phase_pkg::*;
#(
    parameter int unsigned PERIOD  = 8,
    parameter int unsigned PHASE_W = 8
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic [PHASE_W-1:0] phase,
    output logic               clk_out
);

    // One extra bit so cnt + PERIOD cannot overflow when PERIOD == 2**PHASE_W.
    localparam int unsigned EW = PHASE_W + 1;

    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic               clk_out_q, clk_out_d;
    logic [EW-1:0]      diff;

    // Free-running counter and (cnt - phase) mod PERIOD compare.
    always_comb begin
        cnt_d = (cnt_q == PHASE_W'(PERIOD - 1)) ? '0 : cnt_q + PHASE_W'(1);
        if (cnt_q >= phase) begin
            diff = EW'(cnt_q) - EW'(phase);
        end else begin
            diff = EW'(cnt_q) + EW'(PERIOD) - EW'(phase);
        end
        clk_out_d = (diff < EW'(PERIOD / 2));
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

endmodule

// File: rtl/pm_phase_responder.sv
// Responder end of the PLL dynamic phase-step handshake, built in fabric.
// Holds a phase offset, moves it one unit per phasestep handshake and drives a
// square wave of PERIOD cycles delayed by that offset.
//   clk100, reset       : clock, asynchronous active-high reset
//   phasestep           : level request, held until phasedone falls
//   phaseupdown         : 1 = phase+1, 0 = phase-1 (sampled with phasestep)
//   phasecounterselect  : only TARGET_SEL moves the phase (sampled with phasestep)
//   phasedone           : 1 = ready, 0 = step in progress
//   phase               : current offset, 0..PERIOD-1
//   clk_out             : shifted square wave
// Build option: PM_PHASE_WRAP_EN defined -> phase steps modulo PERIOD,
// otherwise it saturates at 0 and PERIOD-1.
module pm_phase_responder
    import pm_phase_pkg::*;
#(
    parameter int unsigned PERIOD      = 8,
    parameter int unsigned PHASE_W     = 8,
    parameter int unsigned TARGET_SEL  = 3,
    parameter int unsigned BUSY_CYCLES = 4
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic               phasestep,
    input  logic               phaseupdown,
    input  logic [2:0]         phasecounterselect,
    output logic               phasedone,
    output logic [PHASE_W-1:0] phase,
    output logic               clk_out
);

`ifdef PM_PHASE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    localparam int unsigned BCW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic               up_q, up_d;
    logic [2:0]         sel_q, sel_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               phasedone_q, phasedone_d;

    // Handshake next-state; phasedone is derived from the next state so it
    // stays aligned with the registered state.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        up_d    = up_q;
        sel_d   = sel_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (phasestep) begin
                    up_d    = phaseupdown;
                    sel_d   = phasecounterselect;
                    state_d = ARM;
                end
            end
            ARM: begin
                bcnt_d  = BCW'(BUSY_CYCLES - 1);
                state_d = BUSY;
            end
            BUSY: begin
                if (bcnt_q == '0) state_d = APPLY;
                else              bcnt_d  = bcnt_q - BCW'(1);
            end
            APPLY: begin
                if (sel_q == 3'(TARGET_SEL)) begin
                    phase_d = PHASE_W'(phase_step(32'(phase_q), up_q, PERIOD, WRAP));
                end
                state_d = RELEASE;
            end
            RELEASE: begin
                // Requester must drop phasestep before another step is taken.
                if (!phasestep) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        phasedone_d = !((state_d == BUSY) || (state_d == APPLY));
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            up_q        <= 1'b0;
            sel_q       <= '0;
            phase_q     <= '0;
            phasedone_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            up_q        <= up_d;
            sel_q       <= sel_d;
            phase_q     <= phase_d;
            phasedone_q <= phasedone_d;
        end
    end

    pm_phase_nco #(
        .PERIOD  (PERIOD),
        .PHASE_W (PHASE_W)
    ) u_nco (
        .clk100  (clk100),
        .reset   (reset),
        .phase   (phase_q),
        .clk_out (clk_out)
    );

    assign phasedone = phasedone_q;
    assign phase     = phase_q;

endmodule
